// File: rtl/v8cpu_gpio_pkg.sv
// v8cpu_gpio_pkg: shared register offsets and reset values
// for the v8cpu GPIO block and its per-port synchroniser.
package v8cpu_gpio_pkg;

  localparam logic [1:0] GPIO_OFS_OUT = 2'd0;
  localparam logic [1:0] GPIO_OFS_DIR = 2'd1;
  localparam logic [1:0] GPIO_OFS_IN  = 2'd2;
  localparam logic [1:0] GPIO_OFS_CHG = 2'd3;

  localparam logic       GPIO_RST_BIT = 1'b0;
  localparam logic [1:0] GPIO_ARM_RST = 2'd0;
  localparam logic [1:0] GPIO_ARM_MAX = 2'd3;

endpackage

// File: rtl/v8cpu_gpio_sync.sv
// v8cpu_gpio_sync: one port's input synchroniser and change flags.
// Ports: clk, reset, pins_in, dir, clr (W1C mask), armed -> s2, chg.
// Option: V8CPU_GPIO_IRQ_EN adds the s3 stage and CHG register.
module v8cpu_gpio_sync
  import v8cpu_gpio_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pins_in,
  input  logic [DATA_W-1:0] dir,
  input  logic [DATA_W-1:0] clr,
  input  logic              armed,
  output logic [DATA_W-1:0] s2,
  output logic [DATA_W-1:0] chg
);

  logic [DATA_W-1:0] s1_q, s1_d;
  logic [DATA_W-1:0] s2_q, s2_d;

  always_comb begin
    s1_d = pins_in;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= {DATA_W{GPIO_RST_BIT}};
      s2_q <= {DATA_W{GPIO_RST_BIT}};
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign s2 = s2_q;

`ifdef V8CPU_GPIO_IRQ_EN
  logic [DATA_W-1:0] s3_q, s3_d;
  logic [DATA_W-1:0] chg_q, chg_d;
  logic [DATA_W-1:0] set;

  // A new edge beats a same-cycle W1C.
  always_comb begin
    s3_d  = s2_q;
    set   = armed ? ((s2_q ^ s3_q) & ~dir) : '0;
    chg_d = (chg_q & ~clr) | set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s3_q  <= {DATA_W{GPIO_RST_BIT}};
      chg_q <= {DATA_W{GPIO_RST_BIT}};
    end else begin
      s3_q  <= s3_d;
      chg_q <= chg_d;
    end
  end

  assign chg = chg_q;
`else
  logic unused_in;
  assign unused_in = ^{dir, clr, armed};
  assign chg = '0;
`endif

endmodule

// File: rtl/v8cpu_gpio.sv
// v8cpu_gpio: NUM_PORTS x DATA_W memory-mapped GPIO on the v8cpu bus.
// Ports: clk, reset, we/re/address/data -> q/q_valid, pins_in,
// pins_out, pins_oe, irq. Macro V8CPU_GPIO_IRQ_EN adds change irq.
module v8cpu_gpio
  import v8cpu_gpio_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                NUM_PORTS = 4,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h800
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        we,
  input  logic                        re,
  input  logic [ADDR_W-1:0]           address,
  input  logic [DATA_W-1:0]           data,
  output logic [DATA_W-1:0]           q,
  output logic                        q_valid,
  input  logic [NUM_PORTS*DATA_W-1:0] pins_in,
  output logic [NUM_PORTS*DATA_W-1:0] pins_out,
  output logic [NUM_PORTS*DATA_W-1:0] pins_oe,
  output logic                        irq
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [ADDR_W:0] BASE_X = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] END_X  =
    BASE_X + (ADDR_W+1)'(4 * NUM_PORTS);

  typedef logic [NUM_PORTS-1:0][DATA_W-1:0] bank_t;

  bank_t out_q, out_d;
  bank_t dir_q, dir_d;
  bank_t in_s2, chg, clr;

  logic              q_valid_q, q_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              armed;

  logic [ADDR_W:0]   addr_x;
  logic [ADDR_W-1:0] addr_rel;
  logic [PW-1:0]     sel;
  logic [1:0]        off;
  logic              hit, wr_hit, rd_fire;
  logic              is_out, is_dir, is_in, is_chg;
  logic              unused_rel;

  assign addr_x   = {1'b0, address};
  assign hit      = (addr_x >= BASE_X) && (addr_x < END_X);
  assign addr_rel = address - BASE_ADDR;
  assign sel      = addr_rel[2 +: PW];
  assign off      = addr_rel[1:0];
  assign unused_rel = ^addr_rel[ADDR_W-1:2+PW];

  assign is_out = (off == GPIO_OFS_OUT);
  assign is_dir = (off == GPIO_OFS_DIR);
  assign is_in  = (off == GPIO_OFS_IN);
  assign is_chg = (off == GPIO_OFS_CHG);

  // Write wins; a simultaneous read is dropped.
  assign wr_hit  = we && hit;
  assign rd_fire = re && !we && hit;

  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    clr   = '0;
    if (wr_hit) begin
      unique case (1'b1)
        is_out: out_d[sel] = data;
        is_dir: dir_d[sel] = data;
        is_chg: clr[sel]   = data;
        default: ;
      endcase
    end
  end

  always_comb begin
    q_valid_d = rd_fire;
    rd_data_d = '0;
    if (rd_fire) begin
      unique case (1'b1)
        is_out: rd_data_d = out_q[sel];
        is_dir: rd_data_d = dir_q[sel];
        is_in:  rd_data_d = in_s2[sel];
        is_chg: rd_data_d = chg[sel];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= '{default: {DATA_W{GPIO_RST_BIT}}};
      dir_q     <= '{default: {DATA_W{GPIO_RST_BIT}}};
      q_valid_q <= 1'b0;
      rd_data_q <= {DATA_W{GPIO_RST_BIT}};
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      q_valid_q <= q_valid_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign pins_out = out_q;
  assign pins_oe  = dir_q;
  assign q_valid  = q_valid_q;
  assign q = q_valid_q ? rd_data_q : {DATA_W{1'bz}};

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    v8cpu_gpio_sync #(
      .DATA_W (DATA_W)
    ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .pins_in (pins_in[i*DATA_W +: DATA_W]),
      .dir     (dir_q[i]),
      .clr     (clr[i]),
      .armed   (armed),
      .s2      (in_s2[i]),
      .chg     (chg[i])
    );
  end

`ifdef V8CPU_GPIO_IRQ_EN
  logic [1:0] arm_q, arm_d;
  logic       irq_q, irq_d;

  // Hold off change detection until the synchroniser has filled.
  always_comb begin
    arm_d = (arm_q == GPIO_ARM_MAX) ? arm_q : arm_q + 2'd1;
    irq_d = |chg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arm_q <= GPIO_ARM_RST;
      irq_q <= 1'b0;
    end else begin
      arm_q <= arm_d;
      irq_q <= irq_d;
    end
  end

  assign armed = (arm_q == GPIO_ARM_MAX);
  assign irq   = irq_q;
`else
  assign armed = 1'b0;
  assign irq   = 1'b0;
`endif

endmodule

// File: tb/tb_v8cpu_gpio.sv
// tb_v8cpu_gpio: directed self-checking bench for v8cpu_gpio
// with default parameters (8-bit, 4 ports, base 'h800).
module tb_v8cpu_gpio;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [15:0] address = '0;
  logic [7:0]  data = '0;
  wire  [7:0]  q;
  logic        q_valid;
  logic [31:0] pins_in = '0;
  logic [31:0] pins_out;
  logic [31:0] pins_oe;
  logic        irq;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] rv;
  logic       rvld;

  always #5 clk = ~clk;

  v8cpu_gpio dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .re       (re),
    .address  (address),
    .data     (data),
    .q        (q),
    .q_valid  (q_valid),
    .pins_in  (pins_in),
    .pins_out (pins_out),
    .pins_oe  (pins_oe),
    .irq      (irq)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a,
                           input logic [7:0] d);
    @(negedge clk);
    we = 1'b1; address = a; data = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a,
                          output logic [7:0] v,
                          output logic vld);
    @(negedge clk);
    re = 1'b1; address = a;
    @(negedge clk);
    re = 1'b0;
    v = q; vld = q_valid;
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] zz;
    zz = 8'bz;
    repeat (3) @(negedge clk);
    chk("rst_qv", {31'd0, q_valid}, 32'd0);
    chk("rst_q", {24'd0, q}, {24'd0, zz});
    chk("rst_out", pins_out, 32'd0);
    chk("rst_oe", pins_oe, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      bus_read(16'h800 + 16'(i), rv, rvld);
      chk($sformatf("rd0_%0d", i), {24'd0, rv}, 32'd0);
      chk($sformatf("rd0v_%0d", i), {31'd0, rvld}, 32'd1);
      @(negedge clk);
      chk($sformatf("rd0drop_%0d", i), {31'd0, q_valid}, 32'd0);
    end

    bus_read(16'h7FF, rv, rvld);
    chk("miss_lo_v", {31'd0, rvld}, 32'd0);
    chk("miss_lo_q", {24'd0, rv}, {24'd0, zz});
    bus_read(16'h810, rv, rvld);
    chk("miss_hi_v", {31'd0, rvld}, 32'd0);

    bus_write(16'h800, 8'hA5);
    chk("out0", {24'd0, pins_out[7:0]}, 32'hA5);
    bus_write(16'h801, 8'hF0);
    chk("oe0", {24'd0, pins_oe[7:0]}, 32'hF0);
    chk("out_oth", {8'd0, pins_out[31:8]}, 32'd0);
    bus_read(16'h800, rv, rvld);
    chk("rb_out", {24'd0, rv}, 32'hA5);
    bus_read(16'h801, rv, rvld);
    chk("rb_dir", {24'd0, rv}, 32'hF0);

    @(negedge clk);
    re = 1'b1; address = 16'h800;
    @(negedge clk);
    chk("b2b_0", {23'd0, q_valid, q}, 32'h1A5);
    address = 16'h801;
    @(negedge clk);
    chk("b2b_1", {23'd0, q_valid, q}, 32'h1F0);
    re = 1'b0;
    @(negedge clk);
    chk("b2b_end", {31'd0, q_valid}, 32'd0);

    pins_in[15:8] = 8'h3C;
    repeat (3) @(negedge clk);
    bus_read(16'h806, rv, rvld);
    chk("in1", {24'd0, rv}, 32'h3C);
    bus_write(16'h806, 8'h11);
    bus_read(16'h806, rv, rvld);
    chk("in1_ro", {24'd0, rv}, 32'h3C);

`ifdef V8CPU_GPIO_IRQ_EN
    bus_read(16'h807, rv, rvld);
    chk("chg1", {24'd0, rv}, 32'h3C);
    chk("irq_p1", {31'd0, irq}, 32'd1);
    bus_write(16'h807, 8'hFF);
    @(negedge clk);
    chk("irq_clr1", {31'd0, irq}, 32'd0);

    bus_write(16'h801, 8'h0F);
    @(negedge clk);
    pins_in[7:0] = 8'hFF;
    @(negedge clk);
    chk("irq_e0", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_e1", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_e2", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_e3", {31'd0, irq}, 32'd1);
    bus_read(16'h803, rv, rvld);
    chk("chg0", {24'd0, rv}, 32'hF0);
    bus_write(16'h803, 8'hF0);
    chk("irq_w1c_n", {31'd0, irq}, 32'd1);
    @(negedge clk);
    chk("irq_w1c_n1", {31'd0, irq}, 32'd0);
    bus_read(16'h803, rv, rvld);
    chk("chg0_clr", {24'd0, rv}, 32'd0);

    // bit 4: sets at E2 and E3; W1C lands on E3.
    @(negedge clk);
    pins_in[4] = 1'b0;
    @(negedge clk);
    pins_in[4] = 1'b1;
    @(negedge clk);
    bus_write(16'h803, 8'h10);
    bus_read(16'h803, rv, rvld);
    chk("set_wins", {24'd0, rv}, 32'h10);
    bus_write(16'h803, 8'h10);
    bus_read(16'h803, rv, rvld);
    chk("w1c_late", {24'd0, rv}, 32'd0);
`else
    @(negedge clk);
    pins_in[7:0] = 8'hFF;
    repeat (5) @(negedge clk);
    bus_read(16'h803, rv, rvld);
    chk("chg0_off", {24'd0, rv}, 32'd0);
    chk("chg0_offv", {31'd0, rvld}, 32'd1);
    bus_read(16'h807, rv, rvld);
    chk("chg1_off", {24'd0, rv}, 32'd0);
    chk("irq_off", {31'd0, irq}, 32'd0);
    bus_write(16'h803, 8'hFF);
    bus_read(16'h803, rv, rvld);
    chk("chg0_wr", {24'd0, rv}, 32'd0);
`endif

    @(negedge clk);
    we = 1'b1; re = 1'b1; address = 16'h800; data = 8'h5A;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    chk("wr_rd_out", {24'd0, pins_out[7:0]}, 32'h5A);
    chk("wr_rd_qv", {31'd0, q_valid}, 32'd0);

    pins_in = 32'hFFFF_FFFF;
    @(negedge clk);
    re = 1'b1; address = 16'h800; reset = 1'b1;
    @(negedge clk);
    re = 1'b0;
    chk("rst_rd_qv", {31'd0, q_valid}, 32'd0);
    chk("rst_rd_out", pins_out, 32'd0);
    chk("rst_rd_oe", pins_oe, 32'd0);
    chk("rst_rd_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("ones_irq", {31'd0, irq}, 32'd0);
    for (int p = 0; p < 4; p++) begin
      bus_read(16'h803 + 16'(4 * p), rv, rvld);
      chk($sformatf("ones_chg_%0d", p), {24'd0, rv}, 32'd0);
      bus_read(16'h802 + 16'(4 * p), rv, rvld);
      chk($sformatf("ones_in_%0d", p), {24'd0, rv}, 32'hFF);
    end
    bus_read(16'h800, rv, rvld);
    chk("post_rst_out", {24'd0, rv}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
